// File: rtl/rv64_mem_pkg.sv
// rv64_mem_pkg: shared types and helpers for the RV64I memory-access stage.
//   ex_op_e    : execute-to-memory operation code (ALU pass, LOAD, STORE, FENCE)
//   state_e    : memory-stage FSM states
//   F3_*       : RV64I load/store funct3 encodings
//   access_size: bytes touched by a funct3[1:0] size code
//   access_ok  : funct3 legality plus natural-alignment check
package rv64_mem_pkg;

  typedef enum logic [1:0] {
    OP_ALU   = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2,
    OP_FENCE = 2'd3
  } ex_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_FENCE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  function automatic logic [3:0] access_size(input logic [1:0] sz);
    access_size = 4'd1 << sz;
  endfunction

  // An encoding with no defined width (LOAD 111, STORE 1xx) is folded into
  // the misaligned case so both take the same fault path.
  function automatic logic access_ok(input logic       is_store,
                                     input logic [2:0] f3,
                                     input logic [2:0] lo);
    logic [3:0] mask;
    logic       f3_ok;
    mask      = access_size(f3[1:0]) - 4'd1;
    f3_ok     = is_store ? ~f3[2] : (f3 != 3'b111);
    access_ok = f3_ok && (({1'b0, lo} & mask) == 4'd0);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane handling for a 64-bit data bus.
//   funct3_i     : load/store funct3 of the latched instruction
//   lane_i       : address bits [2:0] (byte lane of the access)
//   store_data_i : rs2 value to be stored
//   rdata_i      : raw bus read data
//   load_val_o   : extracted and sign/zero-extended load result
//   wdata_o      : store data replicated so the addressed lane carries it
//   wstrb_o      : byte strobes for the store
module mem_lane_align
  import rv64_mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      funct3_i,
  input  logic [2:0]      lane_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] load_val_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [7:0]      wstrb_o
);

  logic [XLEN-1:0] shifted;

  // Move the addressed lane down to bit 0 before extension.
  assign shifted = rdata_i >> {lane_i, 3'b000};

  always_comb begin
    load_val_o = '0;
    case (funct3_i)
      F3_LB:   load_val_o = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      F3_LH:   load_val_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_LW:   load_val_o = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      F3_LD:   load_val_o = shifted;
      F3_LBU:  load_val_o = {{(XLEN-8){1'b0}},  shifted[7:0]};
      F3_LHU:  load_val_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
      F3_LWU:  load_val_o = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: load_val_o = '0;
    endcase
  end

  // Replicating the operand across the bus puts it on every naturally
  // aligned lane, so only the strobe needs to depend on the address.
  always_comb begin
    wdata_o = '0;
    wstrb_o = '0;
    case (funct3_i)
      F3_SB: begin
        wdata_o = {(XLEN/8){store_data_i[7:0]}};
        wstrb_o = 8'h01 << lane_i;
      end
      F3_SH: begin
        wdata_o = {(XLEN/16){store_data_i[15:0]}};
        wstrb_o = 8'h03 << lane_i;
      end
      F3_SW: begin
        wdata_o = {(XLEN/32){store_data_i[31:0]}};
        wstrb_o = 8'h0F << lane_i;
      end
      F3_SD: begin
        wdata_o = store_data_i;
        wstrb_o = 8'hFF;
      end
      default: begin
        wdata_o = '0;
        wstrb_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// memory_access_stage: RV64I memory-access pipeline stage.
// Accepts one instruction from execute, performs loads/stores over a
// single-outstanding bus, holds FENCEs until the memory system is idle, and
// presents a one-cycle result to the downstream register.
//   clk, rst (async, active-low)
//   ex_*      : instruction from execute, ex_ready high only in IDLE
//   mem_*     : request/response bus, mem_idle from the memory system
//   rd_out, io_out_addr, memory_we_out, fence_sig_out, fence_mode_out,
//   fault_out : result, non-zero only in the single DONE cycle
// Optional build macro MEM_TIMEOUT_EN adds a bus-ack timeout of
// TIMEOUT_CYCLES request cycles; without it the bus waits indefinitely.
module memory_access_stage
  import rv64_mem_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [1:0]      ex_op,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [7:0]      ex_fence_sig,
  input  logic [3:0]      ex_fence_mode,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wstrb,
  input  logic            mem_ack,
  input  logic            mem_err,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_idle,
  output logic [XLEN-1:0] rd_out,
  output logic [XLEN-1:0] io_out_addr,
  output logic            memory_we_out,
  output logic [7:0]      fence_sig_out,
  output logic [3:0]      fence_mode_out,
  output logic            fault_out
);

  state_e          state_q, state_d;
  ex_op_e          op_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q, sdata_q;
  logic [7:0]      fsig_q;
  logic [3:0]      fmode_q;
  logic [XLEN-1:0] rd_q, rd_d;
  logic            fault_q, fault_d;
  logic            we_q, we_d;

  logic            accept, in_bus, in_done, is_store_q, expired;
  logic [XLEN-1:0] load_val, lane_wdata;
  logic [7:0]      lane_wstrb;

  assign accept     = (state_q == ST_IDLE) && ex_valid;
  assign in_bus     = (state_q == ST_BUS);
  assign in_done    = (state_q == ST_DONE);
  assign is_store_q = (op_q == OP_STORE);

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .funct3_i     (f3_q),
    .lane_i       (addr_q[2:0]),
    .store_data_i (sdata_q),
    .rdata_i      (mem_rdata),
    .load_val_o   (load_val),
    .wdata_o      (lane_wdata),
    .wstrb_o      (lane_wstrb)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts request cycles without ack; expiry fires during the last allowed
  // request cycle so mem_req is high for exactly TIMEOUT_CYCLES cycles.
  assign cnt_d   = (in_bus && !mem_ack) ? cnt_q + 1'b1 : '0;
  assign expired = in_bus && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  assign expired = 1'b0;

  // TIMEOUT_CYCLES only shapes logic when the timeout is compiled in.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_cfg_unused
  end
`endif

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    fault_d = fault_q;
    we_d    = we_q;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          rd_d    = '0;
          fault_d = 1'b0;
          we_d    = 1'b0;
          case (ex_op_e'(ex_op))
            OP_ALU: begin
              rd_d    = ex_addr;
              state_d = ST_DONE;
            end
            OP_LOAD, OP_STORE: begin
              if (access_ok(ex_op == OP_STORE, ex_funct3, ex_addr[2:0])) begin
                state_d = ST_BUS;
              end else begin
                fault_d = 1'b1;
                state_d = ST_DONE;
              end
            end
            default: state_d = ST_FENCE;
          endcase
        end
      end
      ST_BUS: begin
        // Ack takes priority over a same-cycle timeout expiry.
        if (mem_ack) begin
          state_d = ST_DONE;
          if (mem_err) begin
            fault_d = 1'b1;
            rd_d    = '0;
          end else if (is_store_q) begin
            we_d = 1'b1;
            rd_d = '0;
          end else begin
            rd_d = load_val;
          end
        end else if (expired) begin
          fault_d = 1'b1;
          rd_d    = '0;
          state_d = ST_DONE;
        end
      end
      ST_FENCE: begin
        if (mem_idle) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Data registers need no reset: every output they feed is gated by state.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= ex_op_e'(ex_op);
      f3_q    <= ex_funct3;
      addr_q  <= ex_addr;
      sdata_q <= ex_store_data;
      fsig_q  <= ex_fence_sig;
      fmode_q <= ex_fence_mode;
    end
    rd_q    <= rd_d;
    fault_q <= fault_d;
    we_q    <= we_d;
  end

  assign ex_ready  = (state_q == ST_IDLE);

  assign mem_req   = in_bus;
  assign mem_we    = in_bus && is_store_q;
  assign mem_addr  = in_bus ? {addr_q[XLEN-1:3], 3'b000} : '0;
  assign mem_wdata = (in_bus && is_store_q) ? lane_wdata : '0;
  assign mem_wstrb = (in_bus && is_store_q) ? lane_wstrb : '0;

  assign rd_out         = in_done ? rd_q : '0;
  assign io_out_addr    = in_done ? addr_q : '0;
  assign memory_we_out  = in_done && we_q;
  assign fault_out      = in_done && fault_q;
  assign fence_sig_out  = (in_done && op_q == OP_FENCE) ? fsig_q : '0;
  assign fence_mode_out = (in_done && op_q == OP_FENCE) ? fmode_q : '0;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage with a result scoreboard.
module tb_memory_access_stage;

  localparam logic [1:0] OP_ALU = 2'd0, OP_LOAD = 2'd1, OP_STORE = 2'd2, OP_FENCE = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready;
  logic [1:0]  ex_op;
  logic [2:0]  ex_funct3;
  logic [63:0] ex_addr, ex_store_data;
  logic [7:0]  ex_fence_sig;
  logic [3:0]  ex_fence_mode;
  logic        mem_req, mem_we, mem_ack, mem_err, mem_idle;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wstrb;
  logic [63:0] rd_out, io_out_addr;
  logic        memory_we_out, fault_out;
  logic [7:0]  fence_sig_out;
  logic [3:0]  fence_mode_out;

  memory_access_stage #(.XLEN(64), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_funct3(ex_funct3),
    .ex_addr(ex_addr), .ex_store_data(ex_store_data),
    .ex_fence_sig(ex_fence_sig), .ex_fence_mode(ex_fence_mode),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_err(mem_err), .mem_rdata(mem_rdata),
    .mem_idle(mem_idle),
    .rd_out(rd_out), .io_out_addr(io_out_addr), .memory_we_out(memory_we_out),
    .fence_sig_out(fence_sig_out), .fence_mode_out(fence_mode_out), .fault_out(fault_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int          id;
    logic [63:0] rd;
    logic [63:0] addr;
    logic        we;
    logic        fault;
    logic [7:0]  fs;
    logic [3:0]  fm;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int id, input logic [63:0] rd, input logic [63:0] addr,
                      input logic we, input logic fault, input logic [7:0] fs,
                      input logic [3:0] fm, input int c);
    exp_t e;
    e.id = id; e.rd = rd; e.addr = addr; e.we = we; e.fault = fault;
    e.fs = fs; e.fm = fm; e.cyc = c;
    sb.push_back(e);
  endtask

  // Monitor: the DONE cycle is the one right before ex_ready rises again.
  logic [63:0] p_rd, p_addr;
  logic        p_we, p_fault, p_ready = 1'b1, p_rst = 1'b0;
  logic [7:0]  p_fs;
  logic [3:0]  p_fm;
  int          p_cyc;

  always @(negedge clk) begin
    if (rst && p_rst && ex_ready && !p_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("rd_out#%0d", e.id), p_rd, e.rd);
        chk($sformatf("io_out_addr#%0d", e.id), p_addr, e.addr);
        chk($sformatf("memory_we_out#%0d", e.id), 64'(p_we), 64'(e.we));
        chk($sformatf("fault_out#%0d", e.id), 64'(p_fault), 64'(e.fault));
        chk($sformatf("fence_sig_out#%0d", e.id), 64'(p_fs), 64'(e.fs));
        chk($sformatf("fence_mode_out#%0d", e.id), 64'(p_fm), 64'(e.fm));
        chk($sformatf("done_cycle#%0d", e.id), 64'(p_cyc), 64'(e.cyc));
      end
    end
    if (rst && ex_ready) begin
      chk("idle_bubble", {rd_out | io_out_addr, memory_we_out, fault_out, fence_sig_out, fence_mode_out} == '0 ? 64'd0 : 64'd1, 64'd0);
    end
    p_rd = rd_out; p_addr = io_out_addr; p_we = memory_we_out; p_fault = fault_out;
    p_fs = fence_sig_out; p_fm = fence_mode_out; p_cyc = cyc;
    p_ready = ex_ready; p_rst = rst;
  end

  // Advance to the falling edge of cycle c (always moves at least one edge).
  task automatic wait_cyc(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] sd, input logic [7:0] fs, input logic [3:0] fm,
                       output int n);
    int b;
    b = 0;
    @(negedge clk);
    while (!ex_ready && b < 300) begin
      @(negedge clk);
      b++;
    end
    if (!ex_ready) chk("issue_ready_timeout", 64'(ex_ready), 64'd1);
    ex_valid = 1'b1; ex_op = op; ex_funct3 = f3; ex_addr = a; ex_store_data = sd;
    ex_fence_sig = fs; ex_fence_mode = fm;
    n = cyc;
    @(posedge clk);
    #1 ex_valid = 1'b0;
  endtask

  // Drive one bus transaction: ack arrives dly cycles after mem_req rises.
  task automatic mem_txn(input int n, input int dly, input logic [63:0] e_addr,
                         input logic e_we, input logic [63:0] e_wdata, input logic [7:0] e_wstrb,
                         input logic [63:0] rdata, input logic err);
    int m;
    m = n + 1 + dly;
    wait_cyc(n + 1);
    chk("mem_req_rise", 64'(mem_req), 64'd1);
    if (dly > 0) wait_cyc(m);
    chk("mem_req_hold", 64'(mem_req), 64'd1);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_we", 64'(mem_we), 64'(e_we));
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("mem_wstrb", 64'(mem_wstrb), 64'(e_wstrb));
    mem_ack = 1'b1; mem_rdata = rdata; mem_err = err;
    wait_cyc(m + 1);
    mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = 64'h0;
    chk("mem_req_drop", 64'(mem_req), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2;
    rst = 1'b0; ex_valid = 1'b0; ex_op = 2'd0; ex_funct3 = 3'd0; ex_addr = '0;
    ex_store_data = '0; ex_fence_sig = '0; ex_fence_mode = '0;
    mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = '0; mem_idle = 1'b1;

    repeat (2) @(negedge clk);
    chk("reset_ex_ready", 64'(ex_ready), 64'd1);
    chk("reset_mem_req", 64'(mem_req), 64'd0);
    chk("reset_outputs", {rd_out | io_out_addr | mem_addr | mem_wdata, memory_we_out, fault_out, mem_wstrb}, 64'd0);
    rst = 1'b1;

    // Loads: LD with ack three cycles after the request, then lane/extension cases.
    issue(OP_LOAD, 3'b011, 64'h1000, 64'h0, 8'h0, 4'h0, n);
    push(1, 64'hDEAD_BEEF_0123_4567, 64'h1000, 1'b0, 1'b0, 8'h0, 4'h0, n + 5);
    mem_txn(n, 3, 64'h1000, 1'b0, 64'h0, 8'h00, 64'hDEAD_BEEF_0123_4567, 1'b0);

    issue(OP_LOAD, 3'b000, 64'h1003, 64'h0, 8'h0, 4'h0, n);
    push(2, 64'hFFFF_FFFF_FFFF_FF80, 64'h1003, 1'b0, 1'b0, 8'h0, 4'h0, n + 2);
    mem_txn(n, 0, 64'h1000, 1'b0, 64'h0, 8'h00, 64'h1122_3344_8055_6677, 1'b0);

    issue(OP_LOAD, 3'b100, 64'h1003, 64'h0, 8'h0, 4'h0, n);
    push(3, 64'h80, 64'h1003, 1'b0, 1'b0, 8'h0, 4'h0, n + 3);
    mem_txn(n, 1, 64'h1000, 1'b0, 64'h0, 8'h00, 64'h1122_3344_8055_6677, 1'b0);

    issue(OP_LOAD, 3'b001, 64'h1002, 64'h0, 8'h0, 4'h0, n);
    push(4, 64'hFFFF_FFFF_FFFF_8055, 64'h1002, 1'b0, 1'b0, 8'h0, 4'h0, n + 2);
    mem_txn(n, 0, 64'h1000, 1'b0, 64'h0, 8'h00, 64'h1122_3344_8055_6677, 1'b0);

    issue(OP_LOAD, 3'b101, 64'h1006, 64'h0, 8'h0, 4'h0, n);
    push(5, 64'h1122, 64'h1006, 1'b0, 1'b0, 8'h0, 4'h0, n + 2);
    mem_txn(n, 0, 64'h1000, 1'b0, 64'h0, 8'h00, 64'h1122_3344_8055_6677, 1'b0);

    issue(OP_LOAD, 3'b010, 64'h1004, 64'h0, 8'h0, 4'h0, n);
    push(6, 64'hFFFF_FFFF_89AB_CDEF, 64'h1004, 1'b0, 1'b0, 8'h0, 4'h0, n + 2);
    mem_txn(n, 0, 64'h1000, 1'b0, 64'h0, 8'h00, 64'h89AB_CDEF_0000_0000, 1'b0);

    issue(OP_LOAD, 3'b110, 64'h1004, 64'h0, 8'h0, 4'h0, n);
    push(7, 64'h0000_0000_89AB_CDEF, 64'h1004, 1'b0, 1'b0, 8'h0, 4'h0, n + 2);
    mem_txn(n, 0, 64'h1000, 1'b0, 64'h0, 8'h00, 64'h89AB_CDEF_0000_0000, 1'b0);

    // Stores: lane replication and strobes.
    issue(OP_STORE, 3'b001, 64'h2006, 64'h1111_2222_3333_ABCD, 8'h0, 4'h0, n);
    push(8, 64'h0, 64'h2006, 1'b1, 1'b0, 8'h0, 4'h0, n + 3);
    mem_txn(n, 1, 64'h2000, 1'b1, 64'hABCD_ABCD_ABCD_ABCD, 8'hC0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

    issue(OP_STORE, 3'b000, 64'h2003, 64'h0000_0000_0000_775A, 8'h0, 4'h0, n);
    push(9, 64'h0, 64'h2003, 1'b1, 1'b0, 8'h0, 4'h0, n + 2);
    mem_txn(n, 0, 64'h2000, 1'b1, 64'h5A5A_5A5A_5A5A_5A5A, 8'h08, 64'h0, 1'b0);

    issue(OP_STORE, 3'b010, 64'h2004, 64'hDEAD_BEEF_CAFE_F00D, 8'h0, 4'h0, n);
    push(10, 64'h0, 64'h2004, 1'b1, 1'b0, 8'h0, 4'h0, n + 2);
    mem_txn(n, 0, 64'h2000, 1'b1, 64'hCAFE_F00D_CAFE_F00D, 8'hF0, 64'h0, 1'b0);

    issue(OP_STORE, 3'b011, 64'h2008, 64'h0123_4567_89AB_CDEF, 8'h0, 4'h0, n);
    push(11, 64'h0, 64'h2008, 1'b1, 1'b0, 8'h0, 4'h0, n + 2);
    mem_txn(n, 0, 64'h2008, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 1'b0);

    // Misaligned and invalid-funct3 accesses fault without touching the bus.
    issue(OP_LOAD, 3'b010, 64'h3002, 64'h0, 8'h0, 4'h0, n);
    push(12, 64'h0, 64'h3002, 1'b0, 1'b1, 8'h0, 4'h0, n + 1);
    chk("misaligned_no_req", 64'(mem_req), 64'd0);

    issue(OP_LOAD, 3'b111, 64'h3000, 64'h0, 8'h0, 4'h0, n);
    push(13, 64'h0, 64'h3000, 1'b0, 1'b1, 8'h0, 4'h0, n + 1);
    chk("bad_load_f3_no_req", 64'(mem_req), 64'd0);

    issue(OP_STORE, 3'b100, 64'h3000, 64'h55, 8'h0, 4'h0, n);
    push(14, 64'h0, 64'h3000, 1'b0, 1'b1, 8'h0, 4'h0, n + 1);
    chk("bad_store_f3_no_req", 64'(mem_req), 64'd0);

    // ALU pass, back to back: one instruction every two cycles.
    issue(OP_ALU, 3'b000, 64'hCAFE, 64'h0, 8'h0, 4'h0, n);
    push(15, 64'hCAFE, 64'hCAFE, 1'b0, 1'b0, 8'h0, 4'h0, n + 1);
    issue(OP_ALU, 3'b000, 64'hBEEF, 64'h0, 8'h0, 4'h0, n2);
    push(16, 64'hBEEF, 64'hBEEF, 1'b0, 1'b0, 8'h0, 4'h0, n2 + 1);
    chk("alu_back_to_back_gap", 64'(n2 - n), 64'd2);

    // FENCE held while mem_idle is low.
    mem_idle = 1'b0;
    issue(OP_FENCE, 3'b000, 64'h0, 64'h0, 8'hA5, 4'h8, n);
    push(17, 64'h0, 64'h0, 1'b0, 1'b0, 8'hA5, 4'h8, n + 7);
    wait_cyc(n + 5);
    chk("fence_no_req", 64'(mem_req), 64'd0);
    chk("fence_held_not_ready", 64'(ex_ready), 64'd0);
    @(posedge clk);
    #1 mem_idle = 1'b1;

    // Bus error on a load.
    issue(OP_LOAD, 3'b011, 64'h1008, 64'h0, 8'h0, 4'h0, n);
    push(18, 64'h0, 64'h1008, 1'b0, 1'b1, 8'h0, 4'h0, n + 3);
    mem_txn(n, 1, 64'h1008, 1'b0, 64'h0, 8'h00, 64'hFFFF_0000_FFFF_0000, 1'b1);

    // ex_valid while busy is ignored.
    issue(OP_LOAD, 3'b011, 64'h1018, 64'h0, 8'h0, 4'h0, n);
    push(19, 64'h0123_4567_89AB_CDEF, 64'h1018, 1'b0, 1'b0, 8'h0, 4'h0, n + 4);
    ex_valid = 1'b1; ex_op = OP_ALU; ex_addr = 64'h77;
    mem_txn(n, 2, 64'h1018, 1'b0, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 1'b0);
    ex_valid = 1'b0;

    // Stray ack while idle produces nothing.
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 64'h1234;
    @(negedge clk);
    chk("stray_ack_idle", 64'(ex_ready), 64'd1);
    mem_ack = 1'b0; mem_rdata = 64'h0;
    @(negedge clk);
    chk("stray_ack_no_req", 64'(mem_req), 64'd0);

`ifdef MEM_TIMEOUT_EN
    // No ack: request held four cycles, then a faulting completion.
    issue(OP_LOAD, 3'b011, 64'h1010, 64'h0, 8'h0, 4'h0, n);
    push(20, 64'h0, 64'h1010, 1'b0, 1'b1, 8'h0, 4'h0, n + 5);
    for (int i = 1; i <= 4; i++) begin
      wait_cyc(n + i);
      chk($sformatf("timeout_req_c%0d", i), 64'(mem_req), 64'd1);
    end
    wait_cyc(n + 5);
    chk("timeout_req_drop", 64'(mem_req), 64'd0);

    // Ack in the fourth request cycle wins over expiry.
    issue(OP_LOAD, 3'b011, 64'h1010, 64'h0, 8'h0, 4'h0, n);
    push(21, 64'h5555_AAAA_5555_AAAA, 64'h1010, 1'b0, 1'b0, 8'h0, 4'h0, n + 5);
    mem_txn(n, 3, 64'h1010, 1'b0, 64'h0, 8'h00, 64'h5555_AAAA_5555_AAAA, 1'b0);
`endif

    // Reset in the middle of a bus access: request drops at once, no completion.
    issue(OP_LOAD, 3'b011, 64'h1020, 64'h0, 8'h0, 4'h0, n);
    wait_cyc(n + 2);
    chk("pre_reset_req", 64'(mem_req), 64'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_req_drop", 64'(mem_req), 64'd0);
    chk("async_reset_ready", 64'(ex_ready), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;

    repeat (6) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Memory-access stage of the RV64I pipeline. It sits between execute and the store/write-back pipeline register. It accepts one instruction at a time from execute and runs loads and stores over a single-outstanding memory bus, with byte-lane alignment and sign/zero extension. It holds FENCEs until the memory system reports idle, then presents a one-cycle result (rd value, address, write-enable, fence info) that the downstream register captures.

## Interface
Parameters:
- XLEN, 64, data/address width (`` `XLEN ``).
- TIMEOUT_CYCLES, 256, bus-ack timeout in cycles; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low.
- ex_valid  in  1  execute presents an instruction.
- ex_ready  out  1  stage can accept; high only in IDLE.
- ex_op  in  2  0 = ALU pass, 1 = LOAD, 2 = STORE, 3 = FENCE.
- ex_funct3  in  3  RV64I load/store funct3.
- ex_addr  in  XLEN  effective address (or ALU result for pass).
- ex_store_data  in  XLEN  rs2 value.
- ex_fence_sig  in  8  pred/succ bits.
- ex_fence_mode  in  4  fm field.
- mem_req  out  1  bus request, held until ack or timeout.
- mem_we  out  1  store request.
- mem_addr  out  XLEN  ex_addr with bits [2:0] forced to 0.
- mem_wdata  out  XLEN  store data shifted to its lane.
- mem_wstrb  out  8  byte strobes.
- mem_ack  in  1  request complete this cycle.
- mem_err  in  1  bus error, valid with mem_ack.
- mem_rdata  in  XLEN  load data, valid with mem_ack.
- mem_idle  in  1  memory system has no buffered writes.
- rd_out  out  XLEN  result value.
- io_out_addr  out  XLEN  access address.
- memory_we_out  out  1  completed instruction was a store.
- fence_sig_out  out  8  fence pred/succ.
- fence_mode_out  out  4  fence fm.
- fault_out  out  1  misaligned access, bus error or timeout.

## Operation
- The FSM has four states: IDLE, BUS, FENCE, DONE.
- IDLE: when ex_valid is high, latch all ex_* inputs and choose the next state:
  - ALU pass goes to DONE.
  - LOAD/STORE goes to BUS if the access is aligned. If misaligned, go to DONE with fault_out = 1, and no bus access is made.
  - FENCE goes to FENCE.
- Alignment rule: the address must be a multiple of the access size (1/2/4/8 bytes, from funct3[1:0]).
- Invalid funct3 (LOAD 111, STORE 1xx) is treated as misaligned.
- BUS: mem_req = 1 and request fields are stable.
  - On mem_ack, go to DONE.
  - Load result: extract the lane at addr[2:0], then sign-extend (funct3[2] = 0) or zero-extend (funct3[2] = 1).
  - Store: rd_out = 0, memory_we_out = 1.
  - mem_err with mem_ack: fault_out = 1, rd_out = 0.
- FENCE: wait for mem_idle = 1, then go to DONE.
- DONE: all outputs are valid for exactly one cycle, then return to IDLE.
- Outside DONE, every downstream output is 0 (bubble).
- Store wdata/wstrb: byte = data[7:0] replicated, strobe 1 << lane. Half, word and double follow the same pattern, with strobes 0x3, 0xF or 0xFF shifted by the lane.

## Timing
- Reset: state = IDLE, ex_ready = 1, mem_req = 0; every other output is 0, and the timeout counter is 0.
- Reset asserted mid-access drops mem_req asynchronously. No completion is emitted.
- Accept in cycle N:
  - ALU, misaligned and invalid: DONE in N+1.
  - LOAD/STORE: mem_req rises in N+1. An ack sampled in cycle M gives DONE in M+1. Minimum latency is 2.
  - FENCE: mem_idle sampled high in cycle M gives DONE in M+1. Minimum latency is 2.
- ex_ready is low from N+1 until the cycle after DONE.
- ex_valid while not ready is ignored.
- mem_ack outside BUS is ignored.
- Back-to-back throughput is one instruction per 2 cycles (ALU) or 3+ cycles (memory).

## Configuration
- MEM_TIMEOUT_EN defined:
  - A counter increments each BUS cycle without ack.
  - If no ack has been seen by the end of the TIMEOUT_CYCLES-th request cycle, mem_req drops, the stage goes to DONE, fault_out = 1 and rd_out = 0.
  - Ack and expiry in the same cycle: ack wins.
- MEM_TIMEOUT_EN undefined: BUS waits indefinitely, there is no counter logic, and TIMEOUT_CYCLES is unused.

## Structure
- Package rv64_mem_pkg:
  - ex_op enum
  - FSM state enum
  - funct3 constants (LB..LWU, SB..SD)
  - size decode function
- Sub-module mem_lane_align: combinational load extract/extend and store shift/strobe generation. The FSM and the registers live in the top module.

## Test plan
- Reset, then LD at 0x1000; mem_rdata = 0xDEAD_BEEF_0123_4567, ack 3 cycles after req → rd_out = 0xDEADBEEF01234567 for one cycle, memory_we_out = 0, io_out_addr = 0x1000.
- LB at 0x1003, rdata byte 3 = 0x80 → rd_out = 0xFFFF_FFFF_FFFF_FF80. LBU at the same address → 0x80.
- SH of 0xABCD at 0x2006 → mem_wstrb = 0xC0, mem_wdata[63:48] = 0xABCD, mem_addr = 0x2000, then memory_we_out = 1 and rd_out = 0.
- LW at 0x3002 → no mem_req; fault_out = 1 in N+1.
- FENCE with mem_idle low for 5 cycles → DONE 1 cycle after mem_idle rises, with fence_sig_out and fence_mode_out equal to the inputs.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4, no ack → mem_req high 4 cycles, then fault_out = 1. Repeat with ack on cycle 4 → normal completion.
